// File: rtl/oflow_pkg.sv
// oflow_pkg: shared widths and the loader state encoding for the oflow
// processing-element feeder.
package oflow_pkg;

  localparam int OFLOW_DATA_W = 112;
  localparam int OFLOW_ADDR_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FLUSH,
    DONE
  } loader_state_t;

endpackage

// File: rtl/oflow_pe_loader_if.sv
// oflow_pe_loader_if: descriptor stream in, PE registration write port out,
// plus per-frame status toward the frame controller.
// master = upstream feeder / frame controller side, slave = the loader.
interface oflow_pe_loader_if
  import oflow_pkg::*;
#(
  parameter int DATA_W = OFLOW_DATA_W,
  parameter int ADDR_W = OFLOW_ADDR_W
);

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_ready;

  logic              pe_wr;
  logic [ADDR_W-1:0] pe_addr;
  logic              pe_en;
  logic [DATA_W-1:0] pe_data;

  logic              frame_done;
  logic [ADDR_W:0]   obj_count;
  logic              overflow;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready,
    input  pe_wr, pe_addr, pe_en, pe_data,
    input  frame_done, obj_count, overflow
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready,
    output pe_wr, pe_addr, pe_en, pe_data,
    output frame_done, obj_count, overflow
  );

endinterface

// File: rtl/oflow_pe_loader.sv
// oflow_pe_loader: writes one frame of descriptors into PE storage at
// consecutive addresses, saturating at DEPTH objects and flagging overflow.
// Optional feature macro: OFLOW_LOADER_FRAME_CNT_EN adds a 16-bit wrapping
// frame_cnt output that counts completed frames.
module oflow_pe_loader
  import oflow_pkg::*;
#(
  parameter int DATA_W = OFLOW_DATA_W,
  parameter int ADDR_W = OFLOW_ADDR_W,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset_N,
  oflow_pe_loader_if.slave  bus
`ifdef OFLOW_LOADER_FRAME_CNT_EN
  ,
  output logic [15:0]       frame_cnt
`else
`endif
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W + 1)'(1);

  loader_state_t state;
  logic          accept;

  // in_ready is registered, so it already reflects the current state
  assign accept = bus.in_valid && bus.in_ready;

  // Frame FSM with all outputs registered; in_ready drops only while in DONE
  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) begin
      state          <= IDLE;
      bus.in_ready   <= 1'b1;
      bus.pe_wr      <= 1'b0;
      bus.pe_addr    <= '0;
      bus.pe_data    <= '0;
      bus.pe_en      <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.obj_count  <= '0;
      bus.overflow   <= 1'b0;
    end else begin
      bus.pe_wr      <= 1'b0;
      bus.frame_done <= 1'b0;
      case (state)
        IDLE: begin
          bus.pe_en <= 1'b0;
          if (accept) begin
            bus.pe_wr     <= 1'b1;
            bus.pe_addr   <= '0;
            bus.pe_data   <= bus.in_data;
            bus.pe_en     <= 1'b1;
            bus.obj_count <= ONE_C;
            bus.overflow  <= 1'b0;
            if (bus.in_last) begin
              state          <= DONE;
              bus.in_ready   <= 1'b0;
              bus.frame_done <= 1'b1;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            if (bus.obj_count < DEPTH_C) begin
              bus.pe_wr     <= 1'b1;
              bus.pe_addr   <= bus.obj_count[ADDR_W-1:0];
              bus.pe_data   <= bus.in_data;
              bus.obj_count <= bus.obj_count + ONE_C;
            end else begin
              bus.overflow <= 1'b1;
            end
            if (bus.in_last) begin
              state          <= DONE;
              bus.in_ready   <= 1'b0;
              bus.frame_done <= 1'b1;
            end else if (bus.obj_count >= DEPTH_C) begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (accept && bus.in_last) begin
            state          <= DONE;
            bus.in_ready   <= 1'b0;
            bus.frame_done <= 1'b1;
          end
        end
        DONE: begin
          state        <= IDLE;
          bus.in_ready <= 1'b1;
          bus.pe_en    <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b1;
          bus.pe_en    <= 1'b0;
        end
      endcase
    end
  end

`ifdef OFLOW_LOADER_FRAME_CNT_EN
  // Completed-frame counter, wraps naturally at 16 bits
  always_ff @(posedge clk or posedge reset_N) begin
    if (reset_N) begin
      frame_cnt <= '0;
    end else if (bus.frame_done) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_oflow_pe_loader.sv
// tb_oflow_pe_loader: table-driven frames, hand-written reset sequence and
// random frames, checked by a frame-level scoreboard (DEPTH = 4, ADDR_W = 2).
module tb_oflow_pe_loader;

  localparam int DATA_W = 112;
  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct packed {
    logic [ADDR_W:0] cnt;
    logic            ovf;
  } fr_t;

  typedef struct {
    int n_beats;
    bit gaps;
    bit bub_valid;
    int exp_cnt;
    bit exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic reset_N;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  bit   prev_done = 1'b0;
  int   frames_since_reset = 0;

  wr_t  wq[$];
  fr_t  fq[$];
  vec_t tbl[6];

  oflow_pe_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

`ifdef OFLOW_LOADER_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  oflow_pe_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset_N(reset_N),
    .bus(bus)
`ifdef OFLOW_LOADER_FRAME_CNT_EN
    ,
    .frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rnd_data();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[DATA_W-1:0];
  endfunction

  task automatic check_reset_values();
    checkOutput("rst_in_ready", bus.in_ready, 1);
    checkOutput("rst_pe_wr", bus.pe_wr, 0);
    checkOutput("rst_pe_addr", bus.pe_addr, 0);
    checkOutput("rst_pe_data", bus.pe_data, 0);
    checkOutput("rst_pe_en", bus.pe_en, 0);
    checkOutput("rst_frame_done", bus.frame_done, 0);
    checkOutput("rst_obj_count", bus.obj_count, 0);
    checkOutput("rst_overflow", bus.overflow, 0);
  endtask

  // Drives one frame of n beats; writes and frame result go to the scoreboard.
  // Only the first DEPTH beats of a frame land in PE storage, at addresses 0..DEPTH-1.
  task automatic applyStimulus(input int n, input bit gaps, input bit bub_valid,
                               input int exp_cnt, input bit exp_ovf);
    logic [DATA_W-1:0] d;
    wr_t w;
    fr_t f;
    f.cnt = (ADDR_W + 1)'(exp_cnt);
    f.ovf = exp_ovf;
    fq.push_back(f);
    for (int b = 0; b < n; b++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid = 1'b0;
          bus.in_data  = rnd_data();
          bus.in_last  = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
      end
      d = rnd_data();
      if (b < DEPTH) begin
        w.addr = ADDR_W'(b);
        w.data = d;
        wq.push_back(w);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_last  = (b == n - 1);
      @(negedge clk);
    end
    // bubble cycle: any beat offered here must be ignored
    bus.in_valid = bub_valid;
    bus.in_data  = rnd_data();
    bus.in_last  = 1'($urandom_range(0, 1));
    @(negedge clk);
    bus.in_valid = 1'b0;
    frames_since_reset++;
  endtask

  // Scoreboard monitor, sampling on the falling edge
  always @(negedge clk) begin
    if (mon_en && !reset_N) begin
      checkOutput("in_ready_vs_done", bus.in_ready, !bus.frame_done);
      if (prev_done) begin
        checkOutput("post_done_pe_wr", bus.pe_wr, 0);
        checkOutput("post_done_pe_en", bus.pe_en, 0);
      end
      if (bus.pe_wr) begin
        checkOutput("wr_pe_en", bus.pe_en, 1);
        if (wq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("[TB] FAIL unexpected_pe_wr: got addr %0h, expected no write", bus.pe_addr);
        end else begin
          wr_t w;
          w = wq.pop_front();
          checkOutput("pe_addr", bus.pe_addr, w.addr);
          checkOutput("pe_data", bus.pe_data, w.data);
        end
      end
      if (bus.frame_done) begin
        checkOutput("done_pe_en", bus.pe_en, 1);
        if (fq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("[TB] FAIL unexpected_frame_done: got 1, expected 0");
        end else begin
          fr_t f;
          f = fq.pop_front();
          checkOutput("obj_count", bus.obj_count, f.cnt);
          checkOutput("overflow", bus.overflow, f.ovf);
          checkOutput("writes_before_done", wq.size(), 0);
        end
      end
      prev_done = bus.frame_done;
    end else begin
      prev_done = 1'b0;
    end
  end

  initial begin
    // 3-beat, 1-beat, overflow and exact-fill frames, back to back with in_valid high
    tbl[0] = '{3, 1'b0, 1'b1, 3, 1'b0};
    tbl[1] = '{1, 1'b0, 1'b1, 1, 1'b0};
    tbl[2] = '{6, 1'b0, 1'b1, 4, 1'b1};
    tbl[3] = '{4, 1'b0, 1'b1, 4, 1'b0};
    tbl[4] = '{5, 1'b0, 1'b1, 4, 1'b1};
    tbl[5] = '{2, 1'b1, 1'b0, 2, 1'b0};

    reset_N      = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values();
    reset_N = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(tbl[i].n_beats, tbl[i].gaps, tbl[i].bub_valid,
                    tbl[i].exp_cnt, tbl[i].exp_ovf);
    end
    repeat (2) @(negedge clk);

    // reset mid-frame after two writes: no frame_done, restart at address 0
    begin
      wr_t w;
      for (int b = 0; b < 2; b++) begin
        w.addr = ADDR_W'(b);
        w.data = rnd_data();
        wq.push_back(w);
        bus.in_valid = 1'b1;
        bus.in_data  = w.data;
        bus.in_last  = 1'b0;
        @(negedge clk);
      end
      bus.in_valid = 1'b0;
      @(negedge clk);
      checkOutput("midframe_writes_seen", wq.size(), 0);
      #2 reset_N = 1'b1;
      #1 check_reset_values();
      repeat (2) @(negedge clk);
      reset_N = 1'b0;
      frames_since_reset = 0;
      @(negedge clk);
      applyStimulus(2, 1'b0, 1'b1, 2, 1'b0);
    end

    // random frames with random gaps and bubble beats
    for (int i = 0; i < 30; i++) begin
      int n;
      n = $urandom_range(1, 8);
      applyStimulus(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    (n < DEPTH) ? n : DEPTH, n > DEPTH);
    end

    repeat (4) @(negedge clk);
    checkOutput("writes_drained", wq.size(), 0);
    checkOutput("frames_drained", fq.size(), 0);
`ifdef OFLOW_LOADER_FRAME_CNT_EN
    checkOutput("frame_cnt", frame_cnt, 16'(frames_since_reset));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/oflow_pe_loader.md
# oflow_pe_loader

Upstream feeder for the oflow processing element. Accepts a valid/ready stream of 112-bit object descriptors, one frame at a time. Writes each descriptor into the PE registration storage at consecutive addresses using the PE's wr/addr/EN/data_in port. Reports per-frame object count, completion and overflow to the frame controller.

## Interface
Parameters:
- DATA_W, 112, descriptor width; matches PE data_in.
- ADDR_W, 8, PE address width.
- DEPTH, 256, maximum objects per frame; must be ≤ 2**ADDR_W.

Ports:
- clk: input, 1, single clock, rising edge.
- reset_N: input, 1, asynchronous reset, active-high (asserted = 1).
- in_valid: input, 1, descriptor beat valid.
- in_data: input, DATA_W, object descriptor.
- in_last: input, 1, marks the final beat of a frame.
- in_ready: output, 1, loader accepts a beat when in_valid && in_ready.
- pe_wr: output, 1, PE write strobe.
- pe_addr: output, ADDR_W, PE write address.
- pe_en: output, 1, PE enable; frame in progress.
- pe_data: output, DATA_W, PE write data.
- frame_done: output, 1, one-cycle pulse at end of frame.
- obj_count: output, ADDR_W+1, objects written in the current or last frame.
- overflow: output, 1, current or last frame exceeded DEPTH.

## Operation
- FSM states:
  - IDLE: waiting for the first beat of a frame.
  - LOAD: frame in progress.
  - FLUSH: overflowed; dropping beats until in_last.
  - DONE: single cycle.
- IDLE:
  - in_ready = 1.
  - An accepted beat clears obj_count and overflow, writes at address 0, and sets obj_count = 1.
  - If in_last → DONE, else → LOAD.
- LOAD:
  - in_ready = 1.
  - An accepted beat with obj_count < DEPTH writes at address obj_count, then increments obj_count.
  - If in_last → DONE.
- Overflow: a beat accepted in LOAD with obj_count == DEPTH is not written.
  - overflow is set and obj_count saturates at DEPTH.
  - If that beat has in_last → DONE, else → FLUSH.
- FLUSH:
  - in_ready = 1; beats are discarded with no pe_wr.
  - An accepted in_last → DONE.
- DONE:
  - in_ready = 0.
  - frame_done = 1 for this cycle only; next state is IDLE.
- pe_en is high from the cycle of the first pe_wr of a frame through the frame_done cycle inclusive. It is low in IDLE.
- obj_count and overflow hold their values after DONE until the first accepted beat of the next frame.
- Frames always contain at least one beat; there is no empty-frame case.
- in_data and in_last are ignored when the beat is not accepted.

## Timing
- All outputs are registered.
- Reset values:
  - in_ready = 1 (IDLE).
  - pe_wr = 0, pe_addr = 0, pe_data = 0, pe_en = 0.
  - frame_done = 0, obj_count = 0, overflow = 0.
  - State = IDLE.
- Latency: a beat accepted at edge N appears as pe_wr/pe_addr/pe_data for exactly one cycle after edge N. Sustained throughput is 1 write per cycle.
- frame_done asserts the cycle after the in_last beat is accepted, coincident with that beat's pe_wr (if it was written).
- Back-to-back frames: one-cycle bubble (DONE, in_ready = 0). The next frame's first beat can be accepted the cycle after frame_done.
- Reset asserted mid-frame: all state clears immediately. A partial frame is abandoned with no frame_done.
- Address wrap: none. The address never exceeds DEPTH-1; excess beats go through the overflow path.

## Configuration
- OFLOW_LOADER_FRAME_CNT_EN defined:
  - Adds output frame_cnt, 16 bits, reset 0.
  - Increments on every frame_done cycle and wraps from 0xFFFF to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- oflow_pkg holds:
  - OFLOW_DATA_W = 112 and OFLOW_ADDR_W = 8.
  - The loader state enum (IDLE, LOAD, FLUSH, DONE).
- No sub-module: FSM, counter and output registers are inline in oflow_pe_loader.

## Test plan
- Single 3-beat frame, in_valid held high (D0, D1, D2, last on D2):
  - pe_wr at addresses 0, 1, 2 on consecutive cycles.
  - frame_done with the addr-2 write; obj_count = 3, overflow = 0.
- Single-beat frame (in_last on first beat):
  - One write at addr 0; frame_done the next cycle; obj_count = 1.
- DEPTH = 4, 6-beat frame:
  - Writes at addresses 0–3 only; overflow = 1, obj_count = 4.
  - Beats 5–6 dropped (no pe_wr); frame_done after beat 6.
- Two back-to-back frames with in_valid always high:
  - in_ready low for exactly the frame_done cycle.
  - The second frame restarts at addr 0; obj_count and overflow clear on its first beat.
- Reset asserted mid-frame after 2 writes:
  - All outputs return to reset values; no frame_done.
  - The next frame starts at addr 0.
- With OFLOW_LOADER_FRAME_CNT_EN: 3 frames → frame_cnt = 3.
  - Preloaded to 0xFFFF, one frame → frame_cnt = 0.
